// File: rtl/mux_pkg.sv
// Shared constants and types for the registered 4-to-1 multiplexer.
package mux_pkg;

  localparam int unsigned NUM_INPUTS = 32'd4;
  localparam int unsigned SEL_WIDTH  = 32'd2;

  typedef logic [SEL_WIDTH-1:0] sel_t;

endpackage : mux_pkg

// File: rtl/mux_4to1_comb.sv
// Combinational select decode. An unknown select resolves to an all-zero word
// so that X on sel never reaches the output register.
module mux_4to1_comb
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] data3,
  input  sel_t             sel,
  output logic [WIDTH-1:0] mux_next
);

  if ((32'd1 << SEL_WIDTH) != NUM_INPUTS) begin : g_pkg_check
    $error("mux_pkg: SEL_WIDTH does not decode NUM_INPUTS sources");
  end

  // X or Z on sel matches no item and falls through to the zero default.
  always_comb begin
    mux_next = {WIDTH{1'b0}};
    case (sel)
      2'd0:    mux_next = data0;
      2'd1:    mux_next = data1;
      2'd2:    mux_next = data2;
      2'd3:    mux_next = data3;
      default: mux_next = {WIDTH{1'b0}};
    endcase
  end

endmodule : mux_4to1_comb

// File: rtl/mux_4to1.sv
// Registered 4-to-1 multiplexer: combinational select followed by a single
// asynchronously reset output register.
module mux_4to1 #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned SEL_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     data0,
  input  logic [WIDTH-1:0]     data1,
  input  logic [WIDTH-1:0]     data2,
  input  logic [WIDTH-1:0]     data3,
  input  logic [SEL_WIDTH-1:0] sel,
  output logic [WIDTH-1:0]     data_out
);

  import mux_pkg::*;

  if (SEL_WIDTH != mux_pkg::SEL_WIDTH) begin : g_sel_width_check
    $error("mux_4to1: SEL_WIDTH must be 2");
  end

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  mux_4to1_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .data0    (data0),
    .data1    (data1),
    .data2    (data2),
    .data3    (data3),
    .sel      (sel_t'(sel)),
    .mux_next (data_d)
  );

  // Output register; reset clears it without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= {WIDTH{1'b0}};
    end else begin
      data_q <= data_d;
    end
  end

  assign data_out = data_q;

endmodule : mux_4to1

// File: tb/tb_mux_4to1.sv
// Directed self-checking bench for mux_4to1.
module tb_mux_4to1;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [WIDTH-1:0] data3;
  logic [1:0]       sel;
  logic [WIDTH-1:0] data_out;

  int checks;
  int errors;

  mux_4to1 #(
    .WIDTH     (WIDTH),
    .SEL_WIDTH (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data0    (data0),
    .data1    (data1),
    .data2    (data2),
    .data3    (data3),
    .sel      (sel),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got time %0t, required < 100000", $time);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    data0 = 32'd0; data1 = 32'd0; data2 = 32'd0; data3 = 32'd0;
    sel   = 2'bxx;
    rst   = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (data_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_immediate: got %h, required %h", data_out, 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (data_out !== 32'd0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %h, required %h", i, data_out, 32'd0);
      end
    end
  endtask

  task automatic test_sweep();
    logic [WIDTH-1:0] exp_tbl [4];
    exp_tbl[0] = 32'd7; exp_tbl[1] = 32'd4; exp_tbl[2] = 32'd3; exp_tbl[3] = 32'd8;
    @(negedge clk);
    data0 = 32'd7; data1 = 32'd4; data2 = 32'd3; data3 = 32'd8;
    sel   = 2'd0;
    rst   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sel = 2'(i);
      tick();
      checks++;
      if (data_out !== exp_tbl[i]) begin
        errors++;
        $display("FAIL sweep_sel%0d: got %h, required %h", i, data_out, exp_tbl[i]);
      end
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (data_out !== 32'd8) begin
        errors++;
        $display("FAIL hold[%0d]: got %h, required %h", i, data_out, 32'd8);
      end
    end
    @(negedge clk);
    $display("hold sample: data_out = %0d", data_out);
    checks++;
    if (data_out !== 32'd8) begin
      errors++;
      $display("FAIL hold_display: got %0d, required %0d", data_out, 32'd8);
    end
  endtask

  task automatic test_glitch();
    @(negedge clk);
    sel = 2'd1;
    tick();
    checks++;
    if (data_out !== 32'd4) begin
      errors++;
      $display("FAIL glitch_setup: got %h, required %h", data_out, 32'd4);
    end
    #2;
    data1 = 32'hFFFF_FFFF;
    #2;
    checks++;
    if (data_out !== 32'd4) begin
      errors++;
      $display("FAIL glitch_midcycle: got %h, required %h", data_out, 32'd4);
    end
    data1 = 32'd4;
    tick();
    checks++;
    if (data_out !== 32'd4) begin
      errors++;
      $display("FAIL glitch_after_edge: got %h, required %h", data_out, 32'd4);
    end
    @(negedge clk);
    data1 = 32'hFFFF_FFFF;
    tick();
    checks++;
    if (data_out !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL glitch_capture: got %h, required %h", data_out, 32'hFFFF_FFFF);
    end
    @(negedge clk);
    data1 = 32'd4;
  endtask

  task automatic test_reset_midstream();
    sel = 2'd2;
    tick();
    checks++;
    if (data_out !== 32'd3) begin
      errors++;
      $display("FAIL midrst_setup: got %h, required %h", data_out, 32'd3);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (data_out !== 32'd0) begin
      errors++;
      $display("FAIL midrst_async: got %h, required %h", data_out, 32'd0);
    end
    tick();
    checks++;
    if (data_out !== 32'd0) begin
      errors++;
      $display("FAIL midrst_held: got %h, required %h", data_out, 32'd0);
    end
    @(negedge clk);
    sel = 2'd0;
    data0 = 32'd7;
    rst = 1'b0;
    tick();
    checks++;
    if (data_out !== 32'd7) begin
      errors++;
      $display("FAIL midrst_release: got %h, required %h", data_out, 32'd7);
    end
  endtask

  task automatic test_unknown_sel();
    logic [WIDTH-1:0] expected;
    @(negedge clk);
    data0 = 32'd7; data1 = 32'd4; data2 = 32'd3; data3 = 32'd8;
    sel   = 2'bxx;
    // A two-state simulator turns the X into a real code; expect that source then.
    if ($isunknown(sel)) begin
      expected = 32'd0;
    end else begin
      case (sel)
        2'd0:    expected = 32'd7;
        2'd1:    expected = 32'd4;
        2'd2:    expected = 32'd3;
        default: expected = 32'd8;
      endcase
    end
    tick();
    checks++;
    if (data_out !== expected) begin
      errors++;
      $display("FAIL unknown_sel: got %h, required %h", data_out, expected);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sweep();
    test_hold();
    test_glitch();
    test_reset_midstream();
    test_unknown_sel();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mux_4to1
